// File: rtl/r2mdc_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : r2mdc_stage_ctrl
// Purpose  : Sequencer for one R2MDC stage. It splits each 2D-sample block of
//            an N-point frame into a delay-line fill phase and a butterfly
//            compute phase. Optional macro: R2MDC_CTRL_AUTORESTART_EN
//            (frames stream back-to-back without a new start).
// Revision : 1.0 - initial release
// ============================================================================
module r2mdc_stage_ctrl #(
    parameter int N     = 16,
    parameter int D     = 8,
    parameter int LOG2N = $clog2(N),
    parameter int DW    = $clog2(D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             dl_wr_en,
    output logic [DW-1:0]    dl_addr,
    output logic             bf_en,
    output logic [LOG2N-2:0] tw_addr,
    output logic             out_valid,
    output logic             frame_done
);

    localparam logic [1:0]       c_ST_IDLE    = 2'd0;
    localparam logic [1:0]       c_ST_FILL    = 2'd1;
    localparam logic [1:0]       c_ST_COMPUTE = 2'd2;
    localparam logic [LOG2N-1:0] c_CNT_LAST   = LOG2N'(N - 1);
    localparam logic [DW-1:0]    c_K_LAST     = DW'(D - 1);
    localparam int               c_TW_SHIFT   = LOG2N - 1 - DW;

    logic [1:0]       r_state;
    logic [LOG2N-1:0] r_cnt;
    logic             r_busy;
    logic             r_dl_wr_en;
    logic [DW-1:0]    r_dl_addr;
    logic             r_bf_en;
    logic [LOG2N-2:0] r_tw_addr;
    logic             r_out_valid;
    logic             r_last;
    logic             r_frame_done;

    logic             w_accept;
    logic [DW-1:0]    w_k;
    logic             w_k_last;
    logic             w_cnt_last;
    logic [LOG2N-2:0] w_tw;

    assign in_ready   = (r_state != c_ST_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_k        = r_cnt[DW-1:0];
    assign w_k_last   = (w_k == c_K_LAST);
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // Twiddle index k * N/(2D): a pure left shift since both are powers of two.
    generate
        if (c_TW_SHIFT == 0) begin : g_tw_noshift
            assign w_tw = w_k;
        end else begin : g_tw_shift
            assign w_tw = {w_k, {c_TW_SHIFT{1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_dl_wr_en   <= 1'b0;
            r_dl_addr    <= '0;
            r_bf_en      <= 1'b0;
            r_tw_addr    <= '0;
            r_out_valid  <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dl_wr_en   <= 1'b0;
            r_bf_en      <= 1'b0;
            r_last       <= 1'b0;
            // Second pipeline slot lines up with the registered butterfly output.
            r_out_valid  <= r_bf_en;
            r_frame_done <= r_last;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_FILL;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end

                c_ST_FILL: begin
                    if (w_accept) begin
                        r_dl_wr_en <= 1'b1;
                        r_dl_addr  <= w_k;
                        r_cnt      <= r_cnt + 1'b1;
                        if (w_k_last) begin
                            r_state <= c_ST_COMPUTE;
                        end
                    end
                end

                c_ST_COMPUTE: begin
                    if (w_accept) begin
                        r_bf_en   <= 1'b1;
                        r_dl_addr <= w_k;
                        r_tw_addr <= w_tw;
                        r_cnt     <= r_cnt + 1'b1;
                        if (w_cnt_last) begin
                            r_last  <= 1'b1;
`ifdef R2MDC_CTRL_AUTORESTART_EN
                            r_state <= c_ST_FILL;
`else
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else if (w_k_last) begin
                            r_state <= c_ST_FILL;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign dl_wr_en   = r_dl_wr_en;
    assign dl_addr    = r_dl_addr;
    assign bf_en      = r_bf_en;
    assign tw_addr    = r_tw_addr;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_r2mdc_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_r2mdc_stage_ctrl
// Purpose  : Directed self-checking bench for r2mdc_stage_ctrl (N=16 with
//            D=8 and D=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_r2mdc_stage_ctrl;

`ifdef R2MDC_CTRL_AUTORESTART_EN
    localparam logic c_AUTO = 1'b1;
`else
    localparam logic c_AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start, in_valid;
    logic       in_ready, busy, dl_wr_en, bf_en, out_valid, frame_done;
    logic [2:0] dl_addr;
    logic [2:0] tw_addr;

    logic       start2, in_valid2;
    logic       in_ready2, busy2, dl_wr_en2, bf_en2, out_valid2, frame_done2;
    logic [0:0] dl_addr2;
    logic [2:0] tw_addr2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    r2mdc_stage_ctrl #(.N(16), .D(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .dl_wr_en(dl_wr_en),
        .dl_addr(dl_addr), .bf_en(bf_en), .tw_addr(tw_addr),
        .out_valid(out_valid), .frame_done(frame_done)
    );

    r2mdc_stage_ctrl #(.N(16), .D(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .busy(busy2), .dl_wr_en(dl_wr_en2),
        .dl_addr(dl_addr2), .bf_en(bf_en2), .tw_addr(tw_addr2),
        .out_valid(out_valid2), .frame_done(frame_done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One N=16, D=8 frame from IDLE; optional 1-cycle gaps and a stray start.
    task automatic run_frame(input bit gap, input int start_beat);
        bit prev_bf, prev_last;
        start = 1'b1; in_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("start_no_beat", dl_wr_en, 0);
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        prev_bf = 1'b0; prev_last = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            start = (i == start_beat);
            tick();
            start = 1'b0;
            chk("dl_wr_en", dl_wr_en, i < 8);
            chk("bf_en", bf_en, i >= 8);
            chk("dl_addr", dl_addr, i % 8);
            if (i >= 8) chk("tw_addr", tw_addr, i - 8);
            chk("out_valid", out_valid, prev_bf);
            chk("frame_done", frame_done, prev_last);
            prev_bf = (i >= 8); prev_last = (i == 15);
            if (gap && i < 15) begin
                in_valid = 1'b0;
                tick();
                chk("gap_dl_wr_en", dl_wr_en, 0);
                chk("gap_bf_en", bf_en, 0);
                chk("gap_dl_addr_hold", dl_addr, i % 8);
                chk("gap_out_valid", out_valid, prev_bf);
                chk("gap_frame_done", frame_done, 0);
                prev_bf = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("in_ready_after_last", in_ready, c_AUTO);
        tick();
        chk("last_out_valid", out_valid, 1);
        chk("last_frame_done", frame_done, 1);
        chk("last_bf_en_low", bf_en, 0);
        chk("last_dl_wr_en_low", dl_wr_en, 0);
        tick();
        chk("post_out_valid", out_valid, 0);
        chk("post_frame_done", frame_done, 0);
        chk("post_busy", busy, c_AUTO);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bf_cnt, ph, nfd, first_fd, second_fd;

        // Reset with in_valid held high.
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; start2 = 1'b0; in_valid2 = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dl_wr_en", dl_wr_en, 0);
        chk("rst_dl_addr", dl_addr, 0);
        chk("rst_bf_en", bf_en, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_beat_ignored", dl_wr_en, 0);
        chk("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Back-to-back frame with a stray start during COMPUTE.
        run_frame(1'b0, 10);

        // Gapped frame.
        do_reset();
        run_frame(1'b1, -1);

        // Reset mid-frame after beat 10, then replay.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("pre_rst_bf_en", bf_en, 1);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_bf_en", bf_en, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_dl_addr", dl_addr, 0);
        rst = 1'b0;
        tick();
        chk("mid_rst_out_valid2", out_valid, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        run_frame(1'b0, -1);

        // D=2 instance: fill/compute alternate every two beats.
        do_reset();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        bf_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid2 = 1'b1;
            tick();
            ph = (i / 2) % 2;
            chk("d2_dl_wr_en", dl_wr_en2, ph == 0);
            chk("d2_bf_en", bf_en2, ph == 1);
            chk("d2_dl_addr", dl_addr2, i % 2);
            if (ph == 1) chk("d2_tw_addr", tw_addr2, (i % 2) * 4);
            if (bf_en2) bf_cnt++;
        end
        in_valid2 = 1'b0;
        tick();
        chk("d2_frame_done", frame_done2, 1);
        chk("d2_out_valid", out_valid2, 1);
        chk("d2_bf_count", bf_cnt, 8);

`ifdef R2MDC_CTRL_AUTORESTART_EN
        // Two frames streamed after a single start.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        nfd = 0; first_fd = -1; second_fd = -1;
        for (int c = 0; c < 34; c++) begin
            if (c == 32) in_valid = 1'b0;
            tick();
            chk("auto_in_ready", in_ready, 1);
            if (frame_done) begin
                nfd++;
                if (first_fd < 0) first_fd = c;
                else second_fd = c;
            end
        end
        chk("auto_fd_count", nfd, 2);
        chk("auto_fd_spacing", second_fd - first_fd, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
